// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache. Same-cycle hits; single-word
// refill FSM on the controller's instruction port; saturating hit/miss counters.
module icache_dm #(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q, state_d;
  logic [NSETS-1:0]  valid_q;
  logic [TAGW-1:0]   tag_q  [NSETS];
  logic [31:0]       data_q [NSETS];
  logic [29:0]       maddr_q, maddr_d;   // word address of the pending refill
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic [IDXW-1:0]   idx, fidx;
  logic [TAGW-1:0]   atag, ftag;
  logic              hit, fill, miss;

  // byte offset is irrelevant for word fetches
  logic unused_addr_bits;
  assign unused_addr_bits = ^imemaddr[1:0];

  assign idx  = imemaddr[IDXW+1:2];
  assign atag = imemaddr[31:IDXW+2];
  assign fidx = maddr_q[IDXW-1:0];
  assign ftag = maddr_q[29:IDXW];
  assign hit  = imemREN & valid_q[idx] & (tag_q[idx] == atag);

  assign imemload = ihit ? data_q[idx] : '0;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // next-state and outputs; iREN/iaddr depend on registered state only
  always_comb begin
    state_d = state_q;
    maddr_d = maddr_q;
    fill    = 1'b0;
    miss    = 1'b0;
    ihit    = 1'b0;
    iREN    = 1'b0;
    iaddr   = '0;
    case (state_q)
      IDLE: begin
        ihit = hit;
        if (imemREN && !hit) begin
          miss    = 1'b1;
          maddr_d = imemaddr[31:2];
          state_d = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {maddr_q, 2'b00};
        // a returning word is always good, even if the fetch was withdrawn
        if (!iwait) begin
          fill    = 1'b1;
          state_d = IDLE;
        end else if (!imemREN) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // saturating counter next values; ihit and miss are mutually exclusive
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (ihit && hit_cnt_q != '1)  hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // FSM, refill address and counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      maddr_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      maddr_q    <= maddr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // frame arrays: refill overwrites the frame at the latched index
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < NSETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill) begin
      valid_q[fidx] <= 1'b1;
      tag_q[fidx]   <= ftag;
      data_q[fidx]  <= iload;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: expected fetch words are queued as each
// fetch is issued and compared whenever the cache reports ihit.
module tb_icache_dm;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] hit_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  logic [31:0] sb [$];

  icache_dm #(.NSETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iwait(iwait), .iload(iload),
    .iREN(iREN), .iaddr(iaddr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // backing-memory contents as seen by the controller
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a[31:2] == 30'd0) return 32'h2008_0001;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic step;
    @(posedge CLK); #1;
  endtask

  // one fetch; on a miss the controller answers after lat busy cycles
  task automatic fetch(input logic [31:0] a, input int lat, input bit exp_hit);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
    if (!exp_hit) begin
      @(negedge CLK); chk("miss_ihit", {31'd0, ihit}, 32'd0);
      exp_miss++;
      for (int k = 0; k <= lat; k++) begin
        step;
        iwait = (k < lat);
        iload = (k == lat) ? word(a) : 32'hBAD0_0BAD;
        @(negedge CLK);
        chk("fetch_iren", {31'd0, iREN}, 32'd1);
        chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
      end
      step; iwait = 1'b1;
    end
    sb.push_back(word(a));
    @(negedge CLK); chk("hit_ihit", {31'd0, ihit}, 32'd1);
    exp_hits++;
    step; imemREN = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hits"}, hit_cnt, exp_hits);
    chk({tag, "_miss"}, miss_cnt, exp_miss);
  endtask

  // scoreboard: every ihit must deliver the next queued word
  always @(negedge CLK) begin
    if (nRST && ihit) begin
      if (sb.size() == 0) chk("sb_spurious_hit", imemload, 32'hxxxx_xxxx);
      else chk("sb_imemload", imemload, sb.pop_front());
    end
  end

  initial begin
    // 1: reset values, then cold miss at 0x0 with 3 busy cycles
    #12;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_load", imemload, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk_cnt("rst");
    nRST = 1'b1;
    step;
    fetch(32'h0, 3, 1'b0);
    chk("t1_hits", hit_cnt, 32'd1);
    chk("t1_miss", miss_cnt, 32'd1);

    // 2: conflict in index 0 evicts, re-fetch of 0x0 misses again
    fetch(32'h40, 2, 1'b0);
    fetch(32'h40, 0, 1'b1);
    fetch(32'h0, 0, 1'b0);
    chk("t2_miss", miss_cnt, 32'd3);
    fetch(32'h0, 0, 1'b1);
    chk_cnt("t2");

    // 3: withdraw the fetch while the controller is busy
    imemREN = 1'b1; imemaddr = 32'h84; iwait = 1'b1;
    @(negedge CLK); chk("t3_ihit", {31'd0, ihit}, 32'd0);
    exp_miss++;
    step; @(negedge CLK); chk("t3_iren_a", {31'd0, iREN}, 32'd1);
    step; imemREN = 1'b0;
    @(negedge CLK); chk("t3_iren_b", {31'd0, iREN}, 32'd1);
    step; @(negedge CLK); chk("t3_iren_drop", {31'd0, iREN}, 32'd0);
    step;
    fetch(32'h84, 2, 1'b0);
    chk_cnt("t3");

    // 4: fill lands in the same cycle the request is withdrawn; address
    //    change during the refill must not redirect it
    imemREN = 1'b1; imemaddr = 32'hC8; iwait = 1'b1;
    @(negedge CLK); exp_miss++;
    step; @(negedge CLK); chk("t4_iren", {31'd0, iREN}, 32'd1);
    step; imemREN = 1'b0; imemaddr = 32'h300; iwait = 1'b0; iload = word(32'hC8);
    @(negedge CLK);
    chk("t4_iren_fill", {31'd0, iREN}, 32'd1);
    chk("t4_iaddr_held", iaddr, 32'hC8);
    step; iwait = 1'b1;
    @(negedge CLK); chk("t4_idle", {31'd0, iREN}, 32'd0);
    step;
    fetch(32'hC8, 0, 1'b1);
    chk_cnt("t4");

    // 5: reset during a refill after four frames are filled
    for (int i = 0; i < 4; i++) fetch(32'h100 + 32'(4 * i), 1, 1'b0);
    imemREN = 1'b1; imemaddr = 32'h110; iwait = 1'b1;
    step; @(negedge CLK); chk("t5_iren", {31'd0, iREN}, 32'd1);
    #2 nRST = 1'b0;
    #1 chk("t5_iren_rst", {31'd0, iREN}, 32'd0);
    imemREN = 1'b0;
    exp_hits = 0; exp_miss = 0;
    step; chk_cnt("t5_rst");
    nRST = 1'b1;
    step;
    for (int i = 0; i < 4; i++) fetch(32'h100 + 32'(4 * i), 1, 1'b0);
    chk_cnt("t5");

    // 6: hit counter saturation
    fetch(32'h200, 1, 1'b0);
    force dut.hit_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.hit_cnt_q;
    fetch(32'h200, 0, 1'b1);
    chk("t6_sat_1", hit_cnt, 32'hFFFF_FFFE);
    fetch(32'h200, 0, 1'b1);
    chk("t6_sat_2", hit_cnt, 32'hFFFF_FFFF);
    fetch(32'h200, 0, 1'b1);
    chk("t6_sat_3", hit_cnt, 32'hFFFF_FFFF);
    chk("t6_miss", miss_cnt, exp_miss);

    step;
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
